// File: rtl/game_pkg.sv
// Shared types and constants for the memory-game turn controller.
// Card and FSM encodings are visible on the outputs, so their values are fixed.
package game_pkg;

  localparam int MAX_CARDS = 16;
  localparam int IDX_W     = $clog2(MAX_CARDS);

  typedef enum logic [1:0] {
    HIDDEN = 2'd0,
    FACEUP = 2'd1,
    OWN_P1 = 2'd2,
    OWN_P2 = 2'd3
  } card_t;

  typedef enum logic [2:0] {
    PICK1   = 3'd0,
    PICK2   = 3'd1,
    SHOW    = 3'd2,
    RESOLVE = 3'd3,
    DONE    = 3'd4
  } fsm_t;

  // 1 = P1 ahead, 2 = P2 ahead, 3 = tie
  function automatic logic [1:0] winner_of(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2)      return 2'd1;
    else if (s2 > s1) return 2'd2;
    else              return 2'd3;
  endfunction

endpackage

// File: rtl/match_board.sv
// Per-card state array: face-up write port plus a pair port that either
// claims both cards for a player or hides both again.
module match_board
  import game_pkg::*;
#(
  parameter int N_CARDS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fu_en_i,
  input  logic [IDX_W-1:0]       fu_idx_i,
  input  logic                   own_en_i,
  input  logic                   own_player_i,
  input  logic                   clr_en_i,
  input  logic [IDX_W-1:0]       pair_a_i,
  input  logic [IDX_W-1:0]       pair_b_i,
  output logic [2*N_CARDS-1:0]   card_state_o
);

  card_t cards_q [N_CARDS];
  card_t cards_d [N_CARDS];

  // Pair writes win over the face-up port; the FSM never issues both at once.
  always_comb begin
    for (int i = 0; i < N_CARDS; i++) begin
      cards_d[i] = cards_q[i];
      if ((pair_a_i == IDX_W'(i)) || (pair_b_i == IDX_W'(i))) begin
        if (clr_en_i)      cards_d[i] = HIDDEN;
        else if (own_en_i) cards_d[i] = own_player_i ? OWN_P2 : OWN_P1;
      end
      if (fu_en_i && (fu_idx_i == IDX_W'(i)) && !clr_en_i && !own_en_i)
        cards_d[i] = FACEUP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CARDS; i++) cards_q[i] <= HIDDEN;
    end else begin
      cards_q <= cards_d;
    end
  end

  always_comb begin
    card_state_o = '0;
    for (int i = 0; i < N_CARDS; i++) card_state_o[2*i +: 2] = cards_q[i];
  end

endmodule

// File: rtl/pair_match_ctrl.sv
// Turn controller for the memory game: cursor, two-card pick, timed show,
// resolve/score and player hand-over, ending in a terminal DONE state.
module pair_match_ctrl
  import game_pkg::*;
#(
  parameter int N_CARDS     = 16,
  parameter int LABEL_W     = 4,
  parameter int SHOW_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         move,
  input  logic                         select,
  input  logic [N_CARDS*LABEL_W-1:0]   labels,
  output logic [3:0]                   cursor,
  output logic [2*N_CARDS-1:0]         card_state,
  output logic                         player,
  output logic [3:0]                   score_p1,
  output logic [3:0]                   score_p2,
  output logic                         game_over,
  output logic [1:0]                   winner,
  output logic [2:0]                   fsm_state
);

  localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  fsm_t             state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [IDX_W-1:0] second_q, second_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             player_q, player_d;
  logic [3:0]       score1_q, score1_d;
  logic [3:0]       score2_q, score2_d;
  logic             game_over_q, game_over_d;

  logic             fu_en, own_en, clr_en;
  logic             cur_hidden;
  logic             labels_match;
  logic [4:0]       pairs_won;

  match_board #(.N_CARDS(N_CARDS)) u_board (
    .clk          (clk),
    .rst          (rst),
    .fu_en_i      (fu_en),
    .fu_idx_i     (cursor_q),
    .own_en_i     (own_en),
    .own_player_i (player_q),
    .clr_en_i     (clr_en),
    .pair_a_i     (first_q),
    .pair_b_i     (second_q),
    .card_state_o (card_state)
  );

  assign cur_hidden   = (card_state[{cursor_q, 1'b0} +: 2] == HIDDEN);
  assign labels_match = (labels[int'(first_q)*LABEL_W +: LABEL_W] ==
                         labels[int'(second_q)*LABEL_W +: LABEL_W]);
  assign pairs_won    = 5'(score1_d) + 5'(score2_d);

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    first_d  = first_q;
    second_d = second_q;
    cnt_d    = cnt_q;
    player_d = player_q;
    score1_d = score1_q;
    score2_d = score2_q;
    fu_en    = 1'b0;
    own_en   = 1'b0;
    clr_en   = 1'b0;

    // Select always acts on the pre-increment cursor.
    if (move && (state_q != DONE))
      cursor_d = (cursor_q == IDX_W'(N_CARDS-1)) ? '0 : cursor_q + 1'b1;

    case (state_q)
      PICK1: begin
        if (select && cur_hidden) begin
          fu_en   = 1'b1;
          first_d = cursor_q;
          state_d = PICK2;
        end
      end
      PICK2: begin
        if (select && cur_hidden && (cursor_q != first_q)) begin
          fu_en    = 1'b1;
          second_d = cursor_q;
          cnt_d    = CNT_W'(SHOW_CYCLES-1);
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == '0) state_d = RESOLVE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESOLVE: begin
        if (labels_match) begin
          own_en = 1'b1;
          if (player_q) score2_d = score2_q + 4'd1;
          else          score1_d = score1_q + 4'd1;
        end else begin
          clr_en   = 1'b1;
          player_d = ~player_q;
        end
        state_d = (pairs_won == 5'(N_CARDS/2)) ? DONE : PICK1;
      end
      DONE:    state_d = DONE;
      default: state_d = PICK1;
    endcase
  end

  assign game_over_d = (state_d == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PICK1;
      cursor_q    <= '0;
      cnt_q       <= '0;
      player_q    <= 1'b0;
      score1_q    <= '0;
      score2_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      cnt_q       <= cnt_d;
      player_q    <= player_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      game_over_q <= game_over_d;
    end
  end

  // Picked indices are only meaningful once the FSM has moved past them.
  always_ff @(posedge clk) begin
    first_q  <= first_d;
    second_q <= second_d;
  end

  assign cursor    = 4'(cursor_q);
  assign player    = player_q;
  assign score_p1  = score1_q;
  assign score_p2  = score2_q;
  assign game_over = game_over_q;
  assign winner    = game_over_q ? winner_of(score1_q, score2_q) : 2'd0;
  assign fsm_state = state_q;

endmodule
